// File: rtl/hazard_ctl_pkg.sv
// Shared types for the operand-forwarding producer side: in-flight write slot
// and the mul/div unit state.
package hazard_ctl_pkg;

    localparam int unsigned HZ_RN_W = 5;

    typedef logic [HZ_RN_W-1:0] hz_rn_t;

    typedef struct packed {
        hz_rn_t rn;
        logic   we;
        logic   ld;
    } hz_slot_t;

    localparam hz_slot_t HZ_SLOT_EMPTY = '0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic hz_reads(input logic uses, input hz_rn_t src, input hz_rn_t dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctl_slot.sv
// One pipeline slot of in-flight write info {rn, we, ld}; a sync clear
// inserts an empty slot (bubble), async reset empties it.
module hz_slot
    import hazard_ctl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clr_i,
    input  hz_slot_t d_i,
    output hz_slot_t q_o
);

    hz_slot_t slot_q;
    hz_slot_t slot_d;

    always_comb begin
        slot_d = clr_i ? HZ_SLOT_EMPTY : d_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= HZ_SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/hazard_ctl.sv
// Tracks in-flight register writes through EX/MEM for the forwarding unit and
// raises load-use, mul/div-busy and flush interlocks.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = 33,
    parameter int unsigned CNT_W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [4:0]   id_wr_rn,
    input  logic         id_we,
    input  logic         id_is_load,
    input  logic [4:0]   id_rs_rn,
    input  logic [4:0]   id_rt_rn,
    input  logic         id_uses_rs,
    input  logic         id_uses_rt,
    input  logic         id_is_muldiv,
    input  logic         id_uses_hilo,
    input  logic         id_flush,
    output logic [4:0]   fw_alu_rn,
    output logic         alu_we,
    output logic [4:0]   fw_mem_rn,
    output logic         mem_We,
    output logic         pc_stall,
    output logic         ex_bubble,
    output logic         md_busy
);

    hz_slot_t         ex_q;
    hz_slot_t         mem_q;
    hz_slot_t         ex_d;
    logic             mem_ld_unused;

    logic [CNT_W-1:0] md_cnt_q;
    md_state_e        md_state_q;

    logic             load_use;
    logic             md_stall;
    logic             stall;
    logic             bubble;
    logic             md_issue;

    always_comb begin
        load_use = ex_q.we && ex_q.ld && (ex_q.rn != '0) &&
                   (hz_reads(id_uses_rs, id_rs_rn, ex_q.rn) ||
                    hz_reads(id_uses_rt, id_rt_rn, ex_q.rn));
        md_stall = (md_state_q == MD_BUSY) && (id_uses_hilo || id_is_muldiv);
        // Gated by rst so every output reads 0 while reset is held.
        stall    = !rst && id_valid && !id_flush && (load_use || md_stall);
        bubble   = !rst && (stall || id_flush || !id_valid);
        md_issue = id_valid && id_is_muldiv && !stall && !id_flush;
        ex_d     = '{rn: id_wr_rn, we: id_we && id_valid, ld: id_is_load};
    end

    hz_slot u_ex_slot (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bubble),
        .d_i   (ex_d),
        .q_o   (ex_q)
    );

    hz_slot u_mem_slot (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .d_i   (ex_q),
        .q_o   (mem_q)
    );

    // Issue takes priority over the final decrement so back-to-back ops reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q   <= '0;
            md_state_q <= MD_IDLE;
        end else if (md_issue) begin
            md_cnt_q   <= CNT_W'(MD_CYCLES);
            md_state_q <= MD_BUSY;
        end else if (md_state_q == MD_BUSY) begin
            md_cnt_q <= md_cnt_q - CNT_W'(1);
            if (md_cnt_q == CNT_W'(1)) begin
                md_state_q <= MD_IDLE;
            end
        end
    end

    assign mem_ld_unused = mem_q.ld;

    assign fw_alu_rn = ex_q.rn;
    assign alu_we    = ex_q.we;
    assign fw_mem_rn = mem_q.rn;
    assign mem_We    = mem_q.we;
    assign pc_stall  = stall;
    assign ex_bubble = bubble;
    assign md_busy   = (md_state_q == MD_BUSY);

endmodule
